// File: rtl/sdram_pkg.sv
// Shared widths, request record and scheduler state encoding for the SDRAM
// request front-end.
package sdram_pkg;

  localparam int A_ROW_WIDTH = 13;
  localparam int A_COL_WIDTH = 10;
  localparam int BA_WIDTH    = 2;
  localparam int D_WIDTH     = 16;
  localparam int ADDR_WIDTH  = A_ROW_WIDTH + A_COL_WIDTH;

  typedef struct packed {
    logic                  rw;
    logic [BA_WIDTH-1:0]   ba;
    logic [ADDR_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0]    data;
  } sdram_req_t;

  localparam int REQ_W = $bits(sdram_req_t);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    GAP
  } sched_state_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO with occupancy count; a push is refused while full
// regardless of a same-cycle pop.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [REQ_W-1:0]         i_data,
  input  logic                     i_pop,
  output logic [REQ_W-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CNT_FULL);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/sdram_req_scheduler.sv
// Host-side front-end for the SDRAM controller: queues requests, issues them one
// at a time with an i_initial pulse and returns tagged read data.
//
// state   | meaning
// IDLE    | wait for a queued request and a non-busy controller, then issue
// ISSUE   | o_initial high this cycle; arm the start timeout
// WAIT_HI | wait for the controller to raise busy, or time out
// WAIT_LO | wait for busy to fall; capture read data
// GAP     | enforced idle spacing before the next issue
module sdram_req_scheduler
  import sdram_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_rw,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [BA_WIDTH-1:0]    i_req_ba,
  input  logic [D_WIDTH-1:0]     i_req_data,
  output logic                   o_rd_valid,
  output logic [D_WIDTH-1:0]     o_rd_data,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr,
  output logic [BA_WIDTH-1:0]    o_rd_ba,
  output logic                   o_initial,
  output logic                   o_rw,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic [BA_WIDTH-1:0]    o_ba,
  output logic [D_WIDTH-1:0]     o_wdata,
  input  logic                   i_busy,
  input  logic [D_WIDTH-1:0]     i_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_err_timeout
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  sched_state_t          state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [GW-1:0]         gap_q, gap_d;
  sdram_req_t            req_q, req_d;
  logic                  init_q, init_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [D_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [BA_WIDTH-1:0]   rd_ba_q, rd_ba_d;
  logic                  err_q, err_d;

  logic                  fifo_full, fifo_empty, pop;
  logic [REQ_W-1:0]      fifo_head;
  sdram_req_t            head;

  assign head = sdram_req_t'(fifo_head);

  sdram_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req_valid),
    .i_data  ({i_req_rw, i_req_ba, i_req_addr, i_req_data}),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;
    req_d      = req_q;
    init_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_ba_d    = rd_ba_q;
    err_d      = err_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !i_busy) begin
          pop     = 1'b1;
          req_d   = head;
          init_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = TMR_LOAD;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_busy) begin
          state_d = WAIT_LO;
        end else if (tmr_q == '0) begin
          // Controller never acknowledged: drop the request and move on.
          err_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      WAIT_LO: begin
        if (!i_busy) begin
          if (!req_q.rw) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_rdata;
            rd_addr_d  = req_q.addr;
            rd_ba_d    = req_q.ba;
          end
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      gap_q      <= '0;
      req_q      <= '0;
      init_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_ba_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      req_q      <= req_d;
      init_q     <= init_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_ba_q    <= rd_ba_d;
      err_q      <= err_d;
    end
  end

  assign o_req_ready   = !fifo_full;
  assign o_initial     = init_q;
  assign o_rw          = req_q.rw;
  assign o_addr        = req_q.addr;
  assign o_ba          = req_q.ba;
  assign o_wdata       = req_q.data;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_rd_ba       = rd_ba_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Bench for sdram_req_scheduler: a behavioural controller stub plus a
// memory/order model checks issue order, read data, spacing and error handling.
module tb_sdram_req_scheduler;
  import sdram_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_rw = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [BA_WIDTH-1:0]   req_ba = '0;
  logic [D_WIDTH-1:0]    req_data = '0;
  logic                  busy;
  logic [D_WIDTH-1:0]    rdata;
  logic                  o_req_ready, o_rd_valid, o_initial, o_rw, o_err_timeout;
  logic [D_WIDTH-1:0]    o_rd_data, o_wdata;
  logic [ADDR_WIDTH-1:0] o_rd_addr, o_addr;
  logic [BA_WIDTH-1:0]   o_rd_ba, o_ba;
  logic [$clog2(DEPTH):0] o_count;

  sdram_req_scheduler #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_ba(req_ba), .i_req_data(req_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr), .o_rd_ba(o_rd_ba),
    .o_initial(o_initial), .o_rw(o_rw), .o_addr(o_addr), .o_ba(o_ba), .o_wdata(o_wdata),
    .i_busy(busy), .i_rdata(rdata),
    .o_count(o_count), .o_err_timeout(o_err_timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tot = 0;
  int bad = 0;

  sdram_req_t iss_q[$];
  sdram_req_t rd_q[$];
  logic [D_WIDTH-1:0] model_mem [logic [24:0]];
  logic [D_WIDTH-1:0] stub_mem  [logic [24:0]];

  int  s_mode = 0;
  logic man_busy = 1'b1;
  int  s_phase = 0;
  int  s_cnt = 0;
  bit  s_long = 0;
  bit  s_chk = 0;
  bit  prev_init = 0;
  int  fall_cyc = -100;
  int  init_cyc = -1;
  int  n_init = 0;
  int  rd_seen = 0;
  int  push_cyc = 0;
  logic [D_WIDTH-1:0]    last_rd_data;
  logic [ADDR_WIDTH-1:0] last_rd_addr;
  sdram_req_t cur;

  task automatic stub_proc();
    sdram_req_t e;
    logic [24:0] k;
    busy  = 1'b1;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (o_initial) begin
        tot++;
        if (prev_init) begin bad++; $display("FAIL pulse_width: o_initial high on consecutive cycles at %0d", cyc); end
        tot++;
        if (cyc - fall_cyc < GAP + 1) begin bad++; $display("FAIL gap: issue %0d cycles after busy fall, need >= %0d", cyc - fall_cyc, GAP + 1); end
        init_cyc = cyc;
        n_init++;
        tot++;
        if (iss_q.size() == 0) begin
          bad++; $display("FAIL unexpected_issue: rw=%0b ba=%0d addr=%h, none queued", o_rw, o_ba, o_addr);
        end else begin
          e = iss_q.pop_front();
          if (o_rw !== e.rw || o_addr !== e.addr || o_ba !== e.ba || (e.rw && o_wdata !== e.data)) begin
            bad++;
            $display("FAIL issue_order: got rw=%0b ba=%0d addr=%h wd=%h, want rw=%0b ba=%0d addr=%h wd=%h",
                     o_rw, o_ba, o_addr, o_wdata, e.rw, e.ba, e.addr, e.data);
          end
        end
        cur   = {o_rw, o_ba, o_addr, o_wdata};
        s_chk = 1;
      end
      prev_init = o_initial;
      if (o_rd_valid) begin
        rd_seen++;
        last_rd_data = o_rd_data;
        last_rd_addr = o_rd_addr;
        tot++;
        if (rd_q.size() == 0) begin
          bad++; $display("FAIL unexpected_rd: data=%h addr=%h, no read pending", o_rd_data, o_rd_addr);
        end else begin
          e = rd_q.pop_front();
          if (o_rd_data !== e.data || o_rd_addr !== e.addr || o_rd_ba !== e.ba) begin
            bad++;
            $display("FAIL rd_data: got data=%h ba=%0d addr=%h, want data=%h ba=%0d addr=%h",
                     o_rd_data, o_rd_ba, o_rd_addr, e.data, e.ba, e.addr);
          end
        end
      end
      if (s_chk && s_phase != 0) begin
        tot++;
        if ({o_rw, o_ba, o_addr, o_wdata} !== cur) begin
          bad++; $display("FAIL hold: cmd outputs %h changed, want %h", {o_rw, o_ba, o_addr, o_wdata}, cur);
        end
      end
      case (s_mode)
        0: begin busy = man_busy; s_phase = 0; end
        1: begin
          case (s_phase)
            0: begin
              busy  = 1'b0;
              rdata = D_WIDTH'($urandom);
              if (o_initial) begin s_cnt = $urandom_range(0, 2); s_phase = 1; end
            end
            1: begin
              if (s_cnt == 0) begin
                busy = 1'b1;
                k = {cur.ba, cur.addr};
                if (cur.rw) stub_mem[k] = cur.data;
                else rdata = stub_mem.exists(k) ? stub_mem[k] : '0;
                s_cnt   = s_long ? 12 : $urandom_range(0, 3);
                s_phase = 2;
              end else s_cnt--;
            end
            default: begin
              if (s_cnt == 0) begin
                busy = 1'b0; fall_cyc = cyc; s_phase = 0; s_chk = 0;
              end else s_cnt--;
            end
          endcase
        end
        default: begin busy = 1'b0; s_phase = 0; end
      endcase
    end
  endtask

  task automatic push(input logic rw, input logic [1:0] ba, input logic [ADDR_WIDTH-1:0] addr,
                      input logic [D_WIDTH-1:0] data, output bit acc);
    sdram_req_t r;
    logic [24:0] k;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_ba = ba; req_addr = addr; req_data = data;
    acc = o_req_ready;
    push_cyc = cyc;
    if (acc) begin
      r.rw = rw; r.ba = ba; r.addr = addr; r.data = data;
      iss_q.push_back(r);
      k = {ba, addr};
      if (rw) model_mem[k] = data;
      else begin
        r.data = model_mem.exists(k) ? model_mem[k] : '0;
        rd_q.push_back(r);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((iss_q.size() != 0 || rd_q.size() != 0 || s_phase != 0) && n < limit) begin
      @(negedge clk); n++;
    end
    tot++;
    if (n >= limit) begin bad++; $display("FAIL %s_drain: %0d issues / %0d reads still pending, want 0", name, iss_q.size(), rd_q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tot++;
    if ({o_initial, o_rd_valid, o_rw, o_addr, o_ba, o_wdata, o_rd_data, o_rd_addr, o_rd_ba, o_err_timeout} !== '0 ||
        o_count !== '0 || o_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_state: init=%0b rdv=%0b cnt=%0d rdy=%0b err=%0b, want 0/0/0/1/0",
                      o_initial, o_rd_valid, o_count, o_req_ready, o_err_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_hold();
    bit acc;
    int n0;
    s_mode = 0; man_busy = 1'b1;
    push(1'b1, 2'd0, 23'd0, 16'hABCD, acc);
    idle();
    n0 = n_init;
    repeat (10) @(negedge clk);
    tot++;
    if (n_init != n0 || o_count !== 4'd1) begin
      bad++; $display("FAIL init_hold: %0d issues while busy, count=%0d, want 0 issues count=1", n_init - n0, o_count);
    end
    s_mode = 1;
    repeat (30) @(negedge clk);
    tot++;
    if (n_init != n0 + 1) begin bad++; $display("FAIL init_release: %0d pulses after busy drop, want 1", n_init - n0); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int pc, r0, n;
    init_cyc = -1;
    r0 = rd_seen;
    push(1'b1, 2'd0, 23'd0, 16'hABCD, acc); pc = push_cyc;
    push(1'b1, 2'd0, 23'd1, 16'h1234, acc);
    push(1'b0, 2'd0, 23'd0, 16'h0000, acc);
    idle();
    n = 0;
    while (init_cyc < 0 && n < 50) begin @(negedge clk); n++; end
    tot++;
    if (init_cyc - pc != 2) begin bad++; $display("FAIL latency: push->o_initial %0d cycles, want 2", init_cyc - pc); end
    drain("b2b", 200);
    tot++;
    if (rd_seen - r0 != 1 || last_rd_data !== 16'hABCD || last_rd_addr !== 23'd0) begin
      bad++; $display("FAIL b2b_read: %0d reads last=%h@%h, want 1 read ABCD@0", rd_seen - r0, last_rd_data, last_rd_addr);
    end
    tot++;
    if (stub_mem[25'd0] !== 16'hABCD || stub_mem[25'd1] !== 16'h1234) begin
      bad++; $display("FAIL b2b_mem: bank0[0]=%h bank0[1]=%h, want ABCD 1234", stub_mem[25'd0], stub_mem[25'd1]);
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int p, n;
    init_cyc = -1;
    s_mode = 2;
    push(1'b1, 2'd3, 23'h7F0000, 16'h5555, acc);
    push(1'b0, 2'd0, 23'd1, 16'h0000, acc);
    idle();
    n = 0;
    while (init_cyc < 0 && n < 50) begin @(negedge clk); n++; end
    p = init_cyc;
    @(negedge clk);
    s_mode = 1;
    while (cyc < p + TMO - 2) @(negedge clk);
    tot++;
    if (o_err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: err=%0b at +%0d, want 0", o_err_timeout, cyc - p); end
    while (cyc < p + TMO + 3) @(negedge clk);
    tot++;
    if (o_err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set: err=%0b at +%0d, want 1", o_err_timeout, cyc - p); end
    drain("timeout", 200);
    tot++;
    if (o_err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: err=%0b, want 1", o_err_timeout); end
  endtask

  task automatic test_full();
    bit acc;
    int n0;
    logic [1:0]  rws [8];
    logic [22:0] ads [8];
    rws = '{1, 0, 1, 0, 1, 0, 0, 1};
    ads = '{0, 0, 1, 1, 0, 0, 1, 2};
    s_mode = 0; man_busy = 1'b1;
    repeat (2) @(negedge clk);
    n0 = n_init;
    for (int i = 0; i < 8; i++) begin
      push(rws[i][0], 2'd1, ads[i], 16'h1000 + 16'(i), acc);
      tot++;
      if (!acc) begin bad++; $display("FAIL full_accept: push %0d refused, want accepted", i); end
    end
    push(1'b1, 2'd2, 23'h3, 16'hDEAD, acc);
    tot++;
    if (acc || o_count !== 4'd8) begin bad++; $display("FAIL full_flag: ready=%0b count=%0d, want 0 8", acc, o_count); end
    idle();
    @(negedge clk);
    tot++;
    if (o_count !== 4'd8) begin bad++; $display("FAIL full_ninth: count=%0d after 9th push, want 8", o_count); end
    s_mode = 1;
    drain("full", 500);
    tot++;
    if (n_init - n0 != 8) begin bad++; $display("FAIL full_completions: %0d issued, want 8", n_init - n0); end
  endtask

  task automatic test_flush_reset();
    bit acc;
    int n, r0, n0;
    s_long = 1;
    push(1'b0, 2'd0, 23'd0, 16'h0, acc);
    push(1'b1, 2'd3, 23'h7F0001, 16'h1111, acc);
    push(1'b1, 2'd3, 23'h7F0002, 16'h2222, acc);
    idle();
    n = 0;
    while (s_phase != 2 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    iss_q.delete(); rd_q.delete(); s_chk = 0;
    r0 = rd_seen; n0 = n_init;
    @(negedge clk);
    tot++;
    if (o_count !== '0 || o_initial !== 1'b0 || o_req_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_err_timeout !== 1'b0) begin
      bad++; $display("FAIL flush_state: cnt=%0d init=%0b rdy=%0b rdv=%0b err=%0b, want 0 0 1 0 0",
                      o_count, o_initial, o_req_ready, o_rd_valid, o_err_timeout);
    end
    rst = 1'b0;
    repeat (25) @(negedge clk);
    tot++;
    if (rd_seen != r0 || n_init != n0) begin bad++; $display("FAIL flush_quiet: %0d reads %0d issues after reset, want 0 0", rd_seen - r0, n_init - n0); end
    s_long = 0;
  endtask

  task automatic test_random();
    bit acc;
    int tries, n0;
    logic rw;
    logic [1:0] ba;
    logic [22:0] ad;
    logic [15:0] d;
    s_mode = 1;
    n0 = n_init;
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      ba = 2'($urandom_range(0, 3));
      ad = 23'($urandom_range(0, 7));
      d  = 16'($urandom);
      acc = 0; tries = 0;
      while (!acc && tries < 300) begin push(rw, ba, ad, d, acc); tries++; end
      if (!acc) begin tot++; bad++; $display("FAIL rand_push: request %0d never accepted in %0d cycles", i, tries); end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain("rand", 20000);
    tot++;
    if (n_init - n0 != 200) begin bad++; $display("FAIL rand_count: %0d issued, want 200", n_init - n0); end
  endtask

  initial begin
    fork
      stub_proc();
    join_none
    test_reset();
    test_init_hold();
    test_back_to_back();
    test_timeout();
    test_full();
    test_flush_reset();
    test_random();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
